// File: rtl/facto_pkg.sv
// Shared definitions for the factorial-accelerator host master: register map,
// FSM encoding, opdone status codes and the default accelerator base address.
package facto_pkg;

  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h7000;

  localparam logic [15:0] OFF_OPSTART  = 16'h0000;
  localparam logic [15:0] OFF_OPCLEAR  = 16'h0008;
  localparam logic [15:0] OFF_OPDONE   = 16'h0010;
  localparam logic [15:0] OFF_INTREN   = 16'h0018;
  localparam logic [15:0] OFF_OPERAND  = 16'h0020;
  localparam logic [15:0] OFF_RESULT_H = 16'h0028;
  localparam logic [15:0] OFF_RESULT_L = 16'h0030;

  localparam logic [1:0] OPDONE_BUSY = 2'b10;
  localparam logic [1:0] OPDONE_DONE = 2'b11;

  typedef enum logic [4:0] {
    IDLE    = 5'd0,
    W_CLR1  = 5'd1,
    W_CLR0  = 5'd2,
    W_OPND  = 5'd3,
    W_IEN   = 5'd4,
    W_START = 5'd5,
    WAIT    = 5'd6,
    R_H     = 5'd7,
    R_H_D   = 5'd8,
    R_L     = 5'd9,
    R_L_D   = 5'd10,
    C_CLR1  = 5'd11,
    C_CLR0  = 5'd12,
    C_STOP  = 5'd13,
    OUT     = 5'd14,
    P_RD    = 5'd15,
    P_RD_D  = 5'd16
  } state_t;

  function automatic logic [15:0] reg_addr(input logic [15:0] base, input logic [15:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/facto_timeout_cnt.sv
// Loadable saturating down-counter; zero flags expiry of a loaded interval.
module facto_timeout_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // load takes priority over counting; the count parks at zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= {W{1'b0}};
    end else if (load) begin
      count <= value;
    end else if (en && (count != {W{1'b0}})) begin
      count <= count - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign zero = (count == {W{1'b0}});

endmodule

// File: rtl/facto_host_master.sv
// Bus master driving one factorial accelerator. Define FACTO_HOST_MASTER_POLL_EN
// to poll opdone instead of using the accelerator interrupt.
module facto_host_master
  import facto_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
  parameter logic [31:0] TIMEOUT       = 32'd100000,
  parameter logic [15:0] POLL_INTERVAL = 16'd16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic [63:0] cmd_operand,
  output logic        cmd_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_h,
  output logic [63:0] res_l,
  output logic        res_err,
  output logic        m_req,
  input  logic        m_grant,
  output logic        m_sel,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [63:0] m_dout,
  input  logic [63:0] m_din,
  input  logic        interrupt
);

  state_t      state, next_state, adv;
  logic [63:0] operand, wdata;
  logic [15:0] off;
  logic        bus_cyc, wr_cyc, tmo_fire;
  logic        tmo_load, tmo_en, tmo_zero;

`ifdef FACTO_HOST_MASTER_POLL_EN
  localparam logic [63:0] IEN_VALUE = 64'd0;
  logic poll_load, poll_en, poll_zero;
  logic unused_irq;

  assign unused_irq = interrupt;
  assign poll_en    = (state == WAIT);
  assign poll_load  = ((state == W_START) && m_grant) ||
                      ((state == P_RD_D) && (m_din[1:0] != OPDONE_DONE));

  facto_timeout_cnt #(.W(16)) u_poll_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (poll_load),
    .value   (POLL_INTERVAL - 16'd1),
    .en      (poll_en),
    .zero    (poll_zero)
  );
`else
  localparam logic [63:0] IEN_VALUE = 64'd1;
  logic unused_poll;

  assign unused_poll = ^POLL_INTERVAL;
`endif

  // Timeout keeps running across poll reads so polling cannot extend it
  assign tmo_load = (state == W_START) && m_grant;
  assign tmo_en   = (state == WAIT) || (state == P_RD) || (state == P_RD_D);

  facto_timeout_cnt #(.W(32)) u_tmo_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmo_load),
    .value   (TIMEOUT - 32'd1),
    .en      (tmo_en),
    .zero    (tmo_zero)
  );

  assign cmd_ready = reset_n && (state == IDLE);
  assign res_valid = (state == OUT);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and bus drive; address-phase states only advance when granted
  always_comb begin
    next_state = state;
    m_req      = 1'b0;
    m_sel      = 1'b0;
    m_wr       = 1'b0;
    m_addr     = 16'h0000;
    m_dout     = 64'd0;
    bus_cyc    = 1'b0;
    wr_cyc     = 1'b0;
    off        = OFF_OPSTART;
    wdata      = 64'd0;
    adv        = state;
    tmo_fire   = 1'b0;

    case (state)
      W_CLR1:  begin bus_cyc = 1'b1; wr_cyc = 1'b1; off = OFF_OPCLEAR; wdata = 64'd1;     adv = W_CLR0;  end
      W_CLR0:  begin bus_cyc = 1'b1; wr_cyc = 1'b1; off = OFF_OPCLEAR; wdata = 64'd0;     adv = W_OPND;  end
      W_OPND:  begin bus_cyc = 1'b1; wr_cyc = 1'b1; off = OFF_OPERAND; wdata = operand;   adv = W_IEN;   end
      W_IEN:   begin bus_cyc = 1'b1; wr_cyc = 1'b1; off = OFF_INTREN;  wdata = IEN_VALUE; adv = W_START; end
      W_START: begin bus_cyc = 1'b1; wr_cyc = 1'b1; off = OFF_OPSTART; wdata = 64'd1;     adv = WAIT;    end
      R_H:     begin bus_cyc = 1'b1; off = OFF_RESULT_H; adv = R_H_D;  end
      R_L:     begin bus_cyc = 1'b1; off = OFF_RESULT_L; adv = R_L_D;  end
      P_RD:    begin bus_cyc = 1'b1; off = OFF_OPDONE;   adv = P_RD_D; end
      C_CLR1:  begin bus_cyc = 1'b1; wr_cyc = 1'b1; off = OFF_OPCLEAR; wdata = 64'd1;     adv = C_CLR0;  end
      C_CLR0:  begin bus_cyc = 1'b1; wr_cyc = 1'b1; off = OFF_OPCLEAR; wdata = 64'd0;     adv = C_STOP;  end
      C_STOP:  begin bus_cyc = 1'b1; wr_cyc = 1'b1; off = OFF_OPSTART; wdata = 64'd0;     adv = OUT;     end
      default: begin bus_cyc = 1'b0; end
    endcase

    if (bus_cyc) begin
      m_req  = 1'b1;
      m_sel  = m_grant;
      m_wr   = wr_cyc;
      m_addr = reg_addr(BASE_ADDR, off);
      m_dout = wdata;
      if (m_grant) begin
        next_state = adv;
      end else begin
        next_state = state;
      end
    end else begin
      case (state)
        IDLE: begin
          m_req = cmd_valid;
          if (cmd_valid) begin
            next_state = W_CLR1;
          end else begin
            next_state = IDLE;
          end
        end
`ifdef FACTO_HOST_MASTER_POLL_EN
        WAIT: begin
          if (tmo_zero) begin
            m_req = 1'b1; tmo_fire = 1'b1; next_state = C_CLR1;
          end else if (poll_zero) begin
            m_req = 1'b1; next_state = P_RD;
          end else begin
            next_state = WAIT;
          end
        end
        P_RD_D: begin
          if (m_din[1:0] == OPDONE_DONE) begin
            m_req = 1'b1; next_state = R_H;
          end else begin
            next_state = WAIT;
          end
        end
`else
        WAIT: begin
          if (interrupt) begin
            m_req = 1'b1; next_state = R_H;
          end else if (tmo_zero) begin
            m_req = 1'b1; tmo_fire = 1'b1; next_state = C_CLR1;
          end else begin
            next_state = WAIT;
          end
        end
`endif
        R_H_D: begin m_req = 1'b1; next_state = R_L;    end
        R_L_D: begin m_req = 1'b1; next_state = C_CLR1; end
        OUT: begin
          if (res_ready) begin
            next_state = IDLE;
          end else begin
            next_state = OUT;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Operand latch and result capture; results only change outside OUT
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      operand <= 64'd0;
      res_h   <= 64'd0;
      res_l   <= 64'd0;
      res_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            operand <= cmd_operand;
            res_err <= 1'b0;
          end
        end
        R_H_D: res_h <= m_din;
        R_L_D: res_l <= m_din;
        WAIT: begin
          if (tmo_fire) begin
            res_err <= 1'b1;
            res_h   <= 64'd0;
            res_l   <= 64'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/facto_host_master.md
Name: facto_host_master

Overview:
- Bus-master front end that drives one factorial-accelerator slave on the shared 64-bit system bus.
- Accepts a factorial command (64-bit operand) on a valid/ready port and requests the bus from the arbiter.
- Programs the accelerator's registers, waits for its interrupt, reads back the 128-bit result, clears the accelerator, then returns the result on a valid/ready port.
- Sits directly upstream of the accelerator; it is the only master that talks to that slave.

Parameters:
- BASE_ADDR, 16'h7000, accelerator base address; register address = BASE_ADDR + offset.
- TIMEOUT, 32'd100000, maximum WAIT cycles before abort.
- POLL_INTERVAL, 16'd16, cycles between opdone polls (optional feature only).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_operand  in  64  n for n!
- cmd_ready  out  1  high only in IDLE
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts
- res_h  out  64  result upper word
- res_l  out  64  result lower word
- res_err  out  1  1 = timed out, result words are 0
- m_req  out  1  bus request to arbiter
- m_grant  in  1  bus granted
- m_sel  out  1  slave select, valid only while granted
- m_wr  out  1  1 = write, 0 = read
- m_addr  out  16  byte address
- m_dout  out  64  write data
- m_din  in  64  slave read data, registered by slave
- interrupt  in  1  accelerator interrupt

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n.
- Reset values: all outputs 0, FSM in IDLE, counters 0. Reset mid-operation abandons the bus immediately; the slave is not cleaned up.
- Register offsets: opstart 0x00, opclear 0x08, opdone 0x10, intrEn 0x18, operand 0x20, result_h 0x28, result_l 0x30.
- Bus rules:
  - m_sel is asserted only in a cycle where m_grant=1.
  - Write: one cycle, with m_sel=1, m_wr=1, m_addr and m_dout valid.
  - Read: address cycle (m_sel=1, m_wr=0), then m_din is sampled in the next cycle.
  - If m_grant=0 in a bus state, the FSM holds that state with m_sel=0 and m_req=1.
- FSM states and sequence:
  - IDLE: cmd_ready=1. On cmd_valid, latch the operand, set m_req=1, go to W_CLR1.
  - Writes, one per state: W_CLR1 (opclear=1), W_CLR0 (opclear=0), W_OPND (operand), W_IEN (intrEn=1), W_START (opstart=1).
  - WAIT: m_req=0, timeout counter runs. On interrupt=1, set m_req=1 and go to R_H.
  - R_H: read result_h (address cycle). R_H_D: capture m_din into res_h.
  - R_L: read result_l (address cycle). R_L_D: capture m_din into res_l.
  - C_CLR1: write opclear=1. C_CLR0: write opclear=0. C_STOP: write opstart=0. Then m_req=0, go to OUT.
  - OUT: res_valid=1. On res_ready, go to IDLE.
- Timeout: counter reaching TIMEOUT-1 in WAIT sets res_err=1, zeroes res_h/res_l, and jumps to C_CLR1 (bus re-requested). res_err clears when the next command is accepted.
- Simultaneous interrupt and timeout in the same cycle: interrupt wins.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- res_h, res_l and res_err are held stable while res_valid=1 and res_ready=0.
- Operand 0 or 1 is not special-cased; the slave returns 1.
- Latency, full grant, immediate interrupt: 5 writes + WAIT + 4 read cycles + 3 writes, plus OUT.

Optional Feature:
- Macro: FACTO_HOST_MASTER_POLL_EN.
- Defined:
  - W_IEN writes intrEn=0 and interrupt is ignored.
  - WAIT keeps m_req=0, re-requests the bus every POLL_INTERVAL cycles and reads opdone.
  - Read data with bits[1:0]==2'b11 proceeds to R_H. Any other value releases the bus and restarts the interval.
  - Timeout still applies.
- Undefined: interrupt-driven behaviour as above.

Decomposition:
- Shared package facto_pkg:
  - register offset constants
  - FSM state encoding
  - opdone status codes (2'b10 busy, 2'b11 done)
  - default BASE_ADDR
- One sub-module is natural: facto_timeout_cnt, a loadable down-counter shared by the timeout and poll interval (clk, reset_n, load, value, en, zero).

Test Plan:
- cmd_operand=5, grant always 1, slave model asserts interrupt 40 cycles after opstart -> bus writes in order 0x08=1, 0x08=0, 0x20=5, 0x18=1, 0x00=1; then res_h=0, res_l=120, res_err=0.
- cmd_operand=21 -> res_h=64'h2, res_l=64'hC5077D36B8C40000.
- cmd_operand=0 -> res_h=0, res_l=1; completion cleanup writes 0x08=1, 0x08=0, 0x00=0 are observed.
- m_grant toggled 0/1 every other cycle -> m_sel is never high while m_grant=0; write sequence and result are identical to the 5! case.
- interrupt never asserted, TIMEOUT=50 -> res_err=1, res_h=res_l=0 exactly 50 cycles after entering WAIT; clear writes still issued. With interrupt and timeout on the same cycle, res_err=0.
- reset_n=0 during W_OPND, then cmd_operand=3 -> all outputs 0 the cycle after reset; the new command completes with res_l=6. Separately, res_ready held 0 for 10 cycles -> res_* stable and cmd_ready=0.
